// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM states and the
// bundle of hold/flush controls driven into the pipeline registers.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } hc_state_e;

  typedef struct packed {
    logic pc_hold;
    logic if_id_hold;
    logic if_id_flush;
    logic ctrl_stall;
    logic id_ex_hold;
    logic ex_mem_hold;
    logic mem_wb_flush;
  } hc_ctrl_t;

  localparam hc_ctrl_t HC_IDLE     = '0;
  // Freeze everything up to EX/MEM and bubble MEM/WB.
  localparam hc_ctrl_t HC_HOLD_ALL = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam hc_ctrl_t HC_BRANCH   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam hc_ctrl_t HC_LOADUSE  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    q <= '0;
    else if (inc && (q != '1))   q <= q + 1'b1;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage core: load-use stalls, branch
// flushes, data-memory wait holds with a timeout watchdog, and perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_br_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             if_id_flush,
  output logic             ctrl_stall,
  output logic             id_ex_hold,
  output logic             ex_mem_hold,
  output logic             mem_wb_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

  hc_state_e       state, state_n;
  logic [WC_W-1:0] wait_cnt;
  hc_ctrl_t        ctrl, ctrl_q;
  logic            memwait, loaduse, waiting, wait_inc;

  assign memwait = mem_req & ~mem_ready;
  assign loaduse = ex_mem_read & (ex_rd != 5'd0) &
                   ((ex_rd == id_rs1) | (id_use_rs2 & (ex_rd == id_rs2)));

  always_comb begin
    state_n  = state;
    ctrl     = HC_IDLE;
    wait_inc = 1'b0;
    // Once an access is outstanding only the ack releases it.
    waiting  = (state == MEM_WAIT) ? ~mem_ready : memwait;
    case (state)
      RUN, MEM_WAIT: begin
        if (waiting) begin
          ctrl     = HC_HOLD_ALL;
          wait_inc = 1'b1;
          state_n  = (wait_cnt == WC_LAST) ? ERR : MEM_WAIT;
        end else begin
          state_n = RUN;
          if (ex_br_taken)  ctrl = HC_BRANCH;
          else if (loaduse) ctrl = HC_LOADUSE;
        end
      end
      ERR:     ctrl    = HC_HOLD_ALL;
      default: state_n = RUN;
    endcase
  end

  // Pipeline controls are released for as long as reset is held.
  assign ctrl_q       = rst ? ctrl : HC_IDLE;
  assign pc_hold      = ctrl_q.pc_hold;
  assign if_id_hold   = ctrl_q.if_id_hold;
  assign if_id_flush  = ctrl_q.if_id_flush;
  assign ctrl_stall   = ctrl_q.ctrl_stall;
  assign id_ex_hold   = ctrl_q.id_ex_hold;
  assign ex_mem_hold  = ctrl_q.ex_mem_hold;
  assign mem_wb_flush = ctrl_q.mem_wb_flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_inc ? wait_cnt + 1'b1 : '0;
      if (state_n == ERR) mem_err <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (ctrl_q.pc_hold),
    .q   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (ctrl_q.if_id_flush),
    .q   (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: combinational vector table in RUN, then directed
// multi-cycle sequences for waits, timeout, reset and counter saturation.
module tb_hazard_ctrl;

  localparam int MT = 4;
  localparam int CW = 4;

  // Control vector order: pc_hold, if_id_hold, if_id_flush, ctrl_stall,
  // id_ex_hold, ex_mem_hold, mem_wb_flush
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_HOLD = 7'b1100111;
  localparam logic [6:0] C_BR   = 7'b0011000;
  localparam logic [6:0] C_LU   = 7'b1101000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_use_rs2, ex_mem_read, ex_br_taken, mem_req, mem_ready;
  logic          pc_hold, if_id_hold, if_id_flush, ctrl_stall;
  logic          id_ex_hold, ex_mem_hold, mem_wb_flush, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [6:0]    ctrl_v;

  int n_chk  = 0;
  int n_fail = 0;

  hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs2   (id_use_rs2),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .ex_br_taken  (ex_br_taken),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .pc_hold      (pc_hold),
    .if_id_hold   (if_id_hold),
    .if_id_flush  (if_id_flush),
    .ctrl_stall   (ctrl_stall),
    .id_ex_hold   (id_ex_hold),
    .ex_mem_hold  (ex_mem_hold),
    .mem_wb_flush (mem_wb_flush),
    .mem_err      (mem_err),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  assign ctrl_v = {pc_hold, if_id_hold, if_id_flush, ctrl_stall,
                   id_ex_hold, ex_mem_hold, mem_wb_flush};

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use_rs2;
    logic       ld;
    logic [4:0] rd;
    logic       br;
    logic       req;
    logic       rdy;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic use2,
                       input logic ld, input logic [4:0] rd, input logic br,
                       input logic req, input logic rdy);
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs2 = use2;
    ex_mem_read = ld; ex_rd = rd; ex_br_taken = br;
    mem_req = req; mem_ready = rdy;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Leaves the bench at a negedge with reset released and inputs idle.
  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b0;
    #2;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    //            rs1    rs2    use   ld    rd     br    req   rdy   exp
    tbl[0]  = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, C_NONE};
    tbl[1]  = '{5'd5,  5'd0,  1'b0, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, C_LU};
    tbl[2]  = '{5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, C_NONE};
    tbl[3]  = '{5'd3,  5'd5,  1'b1, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, C_LU};
    tbl[4]  = '{5'd3,  5'd5,  1'b0, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, C_NONE};
    tbl[5]  = '{5'd5,  5'd0,  1'b0, 1'b0, 5'd5,  1'b0, 1'b0, 1'b0, C_NONE};
    tbl[6]  = '{5'd1,  5'd2,  1'b1, 1'b0, 5'd7,  1'b1, 1'b0, 1'b0, C_BR};
    tbl[7]  = '{5'd5,  5'd0,  1'b0, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0, C_BR};
    tbl[8]  = '{5'd5,  5'd0,  1'b0, 1'b1, 5'd5,  1'b1, 1'b1, 1'b0, C_HOLD};
    tbl[9]  = '{5'd5,  5'd0,  1'b0, 1'b1, 5'd5,  1'b0, 1'b1, 1'b1, C_LU};
    tbl[10] = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, C_NONE};
    tbl[11] = '{5'd31, 5'd4,  1'b0, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0, C_LU};

    // Reset state, with hazard-provoking inputs driven
    drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    #1;
    chk("rst_ctrl", 16'(ctrl_v), 16'(C_NONE));
    repeat (2) @(negedge clk);
    chk("rst_err", 16'(mem_err), 16'd0);
    chk("rst_stall_cnt", 16'(stall_cnt), 16'd0);
    chk("rst_flush_cnt", 16'(flush_cnt), 16'd0);
    idle();
    rst = 1'b1;

    // Combinational table in RUN; inputs return to idle before each edge
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(tbl[i].rs1, tbl[i].rs2, tbl[i].use_rs2, tbl[i].ld, tbl[i].rd,
            tbl[i].br, tbl[i].req, tbl[i].rdy);
      #1 chk($sformatf("vec%0d", i), 16'(ctrl_v), 16'(tbl[i].exp));
      #2 idle();
    end
    @(negedge clk);
    chk("tbl_stall_cnt", 16'(stall_cnt), 16'd0);
    chk("tbl_flush_cnt", 16'(flush_cnt), 16'd0);

    // Load-use stall for one cycle
    drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    #1 chk("lu_ctrl", 16'(ctrl_v), 16'(C_LU));
    @(negedge clk);
    idle();
    #1 chk("lu_clear", 16'(ctrl_v), 16'(C_NONE));
    chk("lu_stall_cnt", 16'(stall_cnt), 16'd1);

    // Branch wins over load-use
    @(negedge clk);
    drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    #1 chk("br_lu_ctrl", 16'(ctrl_v), 16'(C_BR));
    @(negedge clk);
    idle();
    #1 chk("br_flush_cnt", 16'(flush_cnt), 16'd1);
    chk("br_stall_cnt", 16'(stall_cnt), 16'd1);

    // 3-cycle memory wait; a frozen branch resolves in the ack cycle
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
      #1 chk($sformatf("w3_hold%0d", k), 16'(ctrl_v), 16'(C_HOLD));
      @(negedge clk);
    end
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
    #1 chk("w3_ack_ctrl", 16'(ctrl_v), 16'(C_BR));
    @(negedge clk);
    idle();
    #1 chk("w3_run_after", 16'(ctrl_v), 16'(C_NONE));
    chk("w3_stall_cnt", 16'(stall_cnt), 16'd3);
    chk("w3_flush_cnt", 16'(flush_cnt), 16'd1);
    chk("w3_err", 16'(mem_err), 16'd0);

    // Zero-wait access: no stall, no state change
    @(negedge clk);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    #1 chk("zw_ctrl", 16'(ctrl_v), 16'(C_NONE));
    @(negedge clk);
    idle();
    #1 chk("zw_after", 16'(ctrl_v), 16'(C_NONE));
    chk("zw_stall_cnt", 16'(stall_cnt), 16'd3);

    // Ack in the would-be timeout cycle completes the access
    do_reset();
    repeat (3) begin
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
    end
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    #1 chk("tb_ack_ctrl", 16'(ctrl_v), 16'(C_NONE));
    @(negedge clk);
    idle();
    #1 chk("tb_ack_err", 16'(mem_err), 16'd0);
    chk("tb_ack_after", 16'(ctrl_v), 16'(C_NONE));

    // Timeout after MT wait cycles, ERR ignores mem_ready
    do_reset();
    for (int k = 0; k < MT; k++) begin
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      #1 chk($sformatf("to_err_pre%0d", k), 16'(mem_err), 16'd0);
      @(negedge clk);
    end
    chk("to_err_set", 16'(mem_err), 16'd1);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
    #1 chk("to_ready_ignored", 16'(ctrl_v), 16'(C_HOLD));
    @(negedge clk);
    idle();
    #1 chk("to_err_hold", 16'(ctrl_v), 16'(C_HOLD));
    chk("to_err_sticky", 16'(mem_err), 16'd1);
    chk("to_stall_cnt", 16'(stall_cnt), 16'd5);
    chk("to_flush_cnt", 16'(flush_cnt), 16'd0);
    rst = 1'b0;
    #1 chk("to_rst_ctrl", 16'(ctrl_v), 16'(C_NONE));
    chk("to_rst_err", 16'(mem_err), 16'd0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("to_rst_run", 16'(ctrl_v), 16'(C_NONE));

    // Reset in the second wait cycle
    do_reset();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #1 chk("mr_hold", 16'(ctrl_v), 16'(C_HOLD));
    rst = 1'b0;
    #1 chk("mr_ctrl", 16'(ctrl_v), 16'(C_NONE));
    chk("mr_stall_cnt", 16'(stall_cnt), 16'd0);
    @(negedge clk);
    idle();
    rst = 1'b1;
    #1 chk("mr_run", 16'(ctrl_v), 16'(C_NONE));
    @(negedge clk);
    chk("mr_stall_after", 16'(stall_cnt), 16'd0);
    chk("mr_err", 16'(mem_err), 16'd0);

    // Saturation: 2^CW+3 load-use stall cycles
    do_reset();
    drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    repeat (15) @(negedge clk);
    chk("sat_15", 16'(stall_cnt), 16'd15);
    repeat ((1 << CW) + 3 - 15) @(negedge clk);
    chk("sat_hold", 16'(stall_cnt), 16'd15);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage core. It watches the ID, EX and MEM stages and drives the stall, hold and flush controls for the pipeline registers. These include `ctrl_stall`, which zeroes the decoded control bundle leaving ID so that a bubble enters EX. It also waits on the data-memory handshake, runs a memory-timeout watchdog and keeps saturating performance counters.

## Interface
Parameters:
- `MEM_TIMEOUT`, 64: maximum number of consecutive MEM_WAIT cycles before an error is raised.
- `CNT_W`, 16: width of each performance counter.

Ports:
- `clk` in 1: core clock.
- `rst` in 1: reset. Asynchronous, active-low.
- `id_rs1` in 5: rs1 field of the instruction in ID.
- `id_rs2` in 5: rs2 field of the instruction in ID.
- `id_use_rs2` in 1: the ID instruction reads rs2 (R-type, store, branch).
- `ex_mem_read` in 1: the instruction in EX is a load.
- `ex_rd` in 5: destination register of the instruction in EX.
- `ex_br_taken` in 1: the branch or jump in EX is resolved taken; redirect is requested.
- `mem_req` in 1: the MEM stage is issuing a data-memory access this cycle.
- `mem_ready` in 1: data-memory ack; the access completes this cycle.
- `pc_hold` out 1: PC keeps its value.
- `if_id_hold` out 1: IF/ID register keeps its value.
- `if_id_flush` out 1: IF/ID register loads a NOP.
- `ctrl_stall` out 1: zeroes the ID control outputs, inserting a bubble into ID/EX.
- `id_ex_hold` out 1: ID/EX register keeps its value.
- `ex_mem_hold` out 1: EX/MEM register keeps its value.
- `mem_wb_flush` out 1: MEM/WB register loads a bubble (regs_write=0).
- `mem_err` out 1: sticky memory-timeout flag.
- `stall_cnt` out CNT_W: number of cycles in which `pc_hold` was 1; saturates.
- `flush_cnt` out CNT_W: number of taken-branch flushes; saturates.

## Operation
- Outputs are Mealy: combinational from the state register and the current-cycle inputs. The same-cycle reaction is required.
- FSM states:
  - RUN: default.
  - MEM_WAIT: an access is outstanding.
  - ERR: a timeout has occurred.
- Event definitions:
  - memwait = `mem_req & !mem_ready`.
  - loaduse = `ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | (id_use_rs2 & ex_rd==id_rs2))`.
- Priority in RUN and MEM_WAIT: memwait, then ex_br_taken, then loaduse, then none.
- memwait response:
  - Outputs: `pc_hold`, `if_id_hold`, `id_ex_hold`, `ex_mem_hold` and `mem_wb_flush` are 1. All other outputs are 0.
  - Transition: RUN→MEM_WAIT. MEM_WAIT stays in MEM_WAIT.
- ex_br_taken response (no memwait):
  - Outputs: `if_id_flush=1`, `ctrl_stall=1`. Holds are 0.
  - `flush_cnt` increments.
  - Branch and load-use in the same cycle: the flush wins, and no hold is applied.
- loaduse response (no memwait, no branch):
  - Outputs: `pc_hold=1`, `if_id_hold=1`, `ctrl_stall=1`. This lasts exactly one cycle; the next cycle the load is in MEM and the hazard clears.
- MEM_WAIT with `mem_ready=1`:
  - No holds this cycle. State returns to RUN.
  - Branch and load-use are evaluated in this same cycle under the normal priority. This covers an `ex_br_taken` that was frozen during the wait.
- Watchdog:
  - `wait_cnt` increments on every MEM_WAIT cycle with `mem_ready=0`.
  - It clears on leaving MEM_WAIT.
  - When `wait_cnt` reaches MEM_TIMEOUT-1 and `mem_ready=0`, the next state is ERR and `mem_err` is set.
- ERR:
  - All four holds and `mem_wb_flush` are 1 permanently. Flush outputs are 0.
  - `mem_err=1`.
  - ERR is left only by reset. `mem_ready` is ignored.
- Counters:
  - `stall_cnt` increments on every cycle with `pc_hold=1`, including ERR.
  - Both counters saturate at all-ones and do not wrap.
- Reset (asserted at any time, including mid-wait):
  - State goes to RUN. `wait_cnt`, `stall_cnt`, `flush_cnt` and `mem_err` go to 0.
  - While `rst=0`, all hold and flush outputs are forced to 0.

## Timing
- Hazard responses have zero latency: the outputs are valid in the same cycle as the inputs.
- State, `wait_cnt`, the counters and `mem_err` update on the rising edge of `clk`.
- A zero-wait access (`mem_req` and `mem_ready` both 1 in the same cycle) causes no stall and no state change.
- An access with N wait cycles, N < MEM_TIMEOUT:
  - Holds are asserted for exactly N cycles.
  - `stall_cnt` increases by N.
- `mem_err` rises on the clock edge that ends the MEM_TIMEOUT-th wait cycle.
- `mem_ready` arriving in that same cycle takes priority: the access completes, the state returns to RUN and no error is raised.
- Outputs must not glitch combinationally through the state; the state is a register.

## Structure
- `hazard_pkg`:
  - state enum {RUN, MEM_WAIT, ERR}, 2 bits.
  - The `hc_ctrl_t` struct bundling the seven hold and flush outputs.
  - Constant `HC_IDLE` (all zero).
- Sub-module `sat_counter` (parameter W; ports `clk`, `rst`, `inc`, `q`), instantiated for `stall_cnt` and `flush_cnt`. `wait_cnt` stays inline because it is cleared by the FSM.

## Test plan
- Load x5 in EX, ID reads rs1=5 → `pc_hold`, `if_id_hold` and `ctrl_stall` are 1 for one cycle; `stall_cnt` goes 0→1. The same case with ex_rd=0 → no stall.
- `ex_br_taken=1` together with a load-use match → `if_id_flush=1`, `ctrl_stall=1`, `pc_hold=0`; `flush_cnt` goes 0→1.
- `mem_req=1` with `mem_ready` low for 3 cycles, then high → the four holds and `mem_wb_flush` are high for exactly 3 cycles; `stall_cnt` becomes 3; the state is RUN after the ack.
- MEM_TIMEOUT=4, `mem_ready` held low → `mem_err` rises after 4 wait cycles; holds stay high with `mem_ready` later pulsed; only `rst=0` clears them.
- Reset asserted on the second MEM_WAIT cycle → all outputs 0 immediately; after release, state RUN and counters 0.
- Force 2^CNT_W+3 load-use stalls with CNT_W=4 → `stall_cnt` holds at 15 and does not wrap.
